bit_sync_ctrl: RTL and testbench
================================

// Module: bit_sync_ctrl
// PURPOSE
// - Parametrised CAN bit-synchronisation controller for the timing module: bus-idle detection,
//   hard synchronisation and SJW-limited resynchronisation in one block.
// - Sits between the edge detector / sample-point generator and the bit-timing counter; its
//   outputs restart (hard sync) or stretch/shrink (resync) the current bit.
// PARAMETERS
// - IDLE_BITS  11  consecutive recessive sample points before bus is declared idle
// - CNT_W      4   idle counter width; must satisfy 2**CNT_W > IDLE_BITS
// - TQ_W       5   width of tq position / segment length fields
// - SJW_W      2   width of sjw input (legal sjw 1..2**SJW_W-1)
// PORTS
// - clock              in   1      system clock
// - reset_n            in   1      asynchronous, active-low reset
// - enable             in   1      sample-point strobe, one cycle per bit
// - signal_in          in   1      sampled bus level (1 = recessive)
// - falling_edge       in   1      recessive->dominant edge strobe, one cycle
// - tq_pos             in   TQ_W   current tq index in bit; 0 = sync segment
// - tseg1              in   TQ_W   prop + phase_seg1 length in tq (>=1)
// - tseg2              in   TQ_W   phase_seg2 length in tq (>=1)
// - sjw                in   SJW_W  synchronisation jump width in tq (>=1)
// - bus_idle           out  1      bus idle flag
// - hard_sync_request  out  1      one-cycle pulse: restart bit at sync segment
// - resync_valid       out  1      one-cycle pulse: apply resync_amount
// - resync_lengthen    out  1      1 = lengthen phase_seg1, 0 = shorten phase_seg2
// - resync_amount      out  TQ_W   tq correction, min(|phase error|, sjw)
// BEHAVIOUR
// - Reset: idle counter 0, state BUSY, bus_idle 0, all pulses 0, resync_amount 0, sync_lock 0.
// - FSM BUSY/IDLE on enable: signal_in=1 -> counter += 1, saturating at IDLE_BITS;
//   signal_in=0 -> counter 0, state BUSY. BUSY->IDLE when enable seen with counter==IDLE_BITS
//   and signal_in=1 (i.e. IDLE_BITS+1 recessive samples, matches existing idle timing).
//   bus_idle = (state==IDLE), registered.
// - enable low: counter and state hold; edges are still evaluated.
// - Edge evaluation uses registered state/bus_idle as it was before the current cycle's update.
// - falling_edge while IDLE: hard_sync_request=1 next cycle; state->BUSY, counter 0; no resync.
// - falling_edge while BUSY and sync_lock=0, phase error p = tq_pos:
//   p==0 -> no action; 1<=p<=tseg1 -> late: lengthen=1, amount=min(p,sjw);
//   tseg1<p<=tseg1+tseg2 -> early: lengthen=0, amount=min(tseg1+tseg2+1-p,sjw);
//   p>tseg1+tseg2 -> ignored. Any valid resync pulses resync_valid for one cycle.
// - sync_lock: set by any hard sync or resync; cleared by enable. At most one sync per bit.
//   enable and falling_edge in same cycle: edge evaluated with old lock, then lock cleared.
// - Arithmetic at TQ_W+1 bits internally; amount never exceeds sjw nor wraps.
// - Latency: all outputs registered, 1 cycle after causing strobe. Pulses last exactly 1 cycle.
// - resync_lengthen/resync_amount hold last value between pulses.
// - reset_n low mid-bit: immediate return to reset values, pending pulses dropped.
// CONFIGURATION
// - SYNC_STATS_EN defined: adds outputs hard_sync_count[15:0], resync_count[15:0], saturating
//   at 16'hFFFF, increment on each respective pulse, cleared by reset only.
// - SYNC_STATS_EN undefined: counters and ports absent; all other behaviour identical.
// TESTING
// - 12 enables signal_in=1 -> bus_idle=1 one cycle after 12th enable; 11 enables -> stays 0.
// - Idle bus, falling_edge -> hard_sync_request 1 cycle, bus_idle=0, no resync_valid.
// - BUSY, tseg1=7,tseg2=4,sjw=2, edge tq_pos=3 -> resync_valid, lengthen=1, amount=2;
//   tq_pos=1 -> amount=1.
// - Same timing, edge tq_pos=10 -> lengthen=0, amount=min(2,2)=2; tq_pos=0 -> no pulse.
// - Two edges in one bit -> only first produces resync; next enable re-arms.
// - reset_n pulled low while bus_idle=1 and edge pending -> all outputs 0, counter restarts;
//   with SYNC_STATS_EN, counts verified after 3 hard syncs and 2 resyncs = 3 / 2.

Source files
------------

// File: rtl/bit_sync_ctrl.sv
// bit_sync_ctrl: CAN bit-synchronisation controller.
//   Detects bus idle (IDLE_BITS+1 recessive sample points), issues a hard
//   sync on the first falling edge of an idle bus, and otherwise computes an
//   SJW-limited resynchronisation from the edge phase error. At most one sync
//   is accepted per bit; the sample-point strobe re-arms it.
//
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   enable                 sample-point strobe, one cycle per bit
//   signal_in              sampled bus level (1 = recessive)
//   falling_edge           recessive->dominant edge strobe
//   tq_pos                 current tq index in the bit (0 = sync segment)
//   tseg1, tseg2           segment lengths in tq
//   sjw                    synchronisation jump width in tq
//   bus_idle               registered bus idle flag
//   hard_sync_request      one-cycle pulse, restart bit at sync segment
//   resync_valid           one-cycle pulse, apply resync_amount
//   resync_lengthen        1 = lengthen phase_seg1, 0 = shorten phase_seg2
//   resync_amount          tq correction, min(|phase error|, sjw)
//
// Optional feature (macro SYNC_STATS_EN):
//   hard_sync_count, resync_count  saturating 16-bit event counters

module bit_sync_ctrl #(
    parameter int unsigned IDLE_BITS = 11,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned TQ_W      = 5,
    parameter int unsigned SJW_W     = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             signal_in,
    input  logic             falling_edge,
    input  logic [TQ_W-1:0]  tq_pos,
    input  logic [TQ_W-1:0]  tseg1,
    input  logic [TQ_W-1:0]  tseg2,
    input  logic [SJW_W-1:0] sjw,
    output logic             bus_idle,
    output logic             hard_sync_request,
    output logic             resync_valid,
    output logic             resync_lengthen,
    output logic [TQ_W-1:0]  resync_amount
`ifdef SYNC_STATS_EN
    ,
    output logic [15:0]      hard_sync_count,
    output logic [15:0]      resync_count
`endif
);

    localparam int unsigned EXT_W = TQ_W + 1;
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_BITS);

    typedef enum logic {
        BUSY = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lock_q, lock_d;
    logic              hs_d, rv_d, len_d;
    logic [TQ_W-1:0]   amt_d;

    // Phase-error arithmetic, one bit wider than the tq fields so nothing wraps
    logic [EXT_W-1:0]  p_ext, seg1_ext, seg_end, sjw_ext, early_err;
    logic [EXT_W-1:0]  late_amt, early_amt;
    logic              is_late, is_early;

    assign p_ext     = EXT_W'(tq_pos);
    assign seg1_ext  = EXT_W'(tseg1);
    assign seg_end   = seg1_ext + EXT_W'(tseg2);
    assign sjw_ext   = EXT_W'(sjw);
    assign early_err = seg_end + EXT_W'(1) - p_ext;
    assign late_amt  = (p_ext < sjw_ext) ? p_ext : sjw_ext;
    assign early_amt = (early_err < sjw_ext) ? early_err : sjw_ext;
    assign is_late   = (p_ext != '0) && (p_ext <= seg1_ext);
    assign is_early  = (p_ext > seg1_ext) && (p_ext <= seg_end);

    // Next-state and next-output logic; edges see the pre-update state/lock
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        hs_d    = 1'b0;
        rv_d    = 1'b0;
        len_d   = resync_lengthen;
        amt_d   = resync_amount;

        if (enable) begin
            if (signal_in) begin
                if (cnt_q == IDLE_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d   = '0;
                state_d = BUSY;
            end
        end

        if (falling_edge) begin
            if (state_q == IDLE) begin
                hs_d    = 1'b1;
                state_d = BUSY;
                cnt_d   = '0;
                lock_d  = 1'b1;
            end else if (!lock_q) begin
                if (is_late) begin
                    rv_d   = 1'b1;
                    len_d  = 1'b1;
                    amt_d  = TQ_W'(late_amt);
                    lock_d = 1'b1;
                end else if (is_early) begin
                    rv_d   = 1'b1;
                    len_d  = 1'b0;
                    amt_d  = TQ_W'(early_amt);
                    lock_d = 1'b1;
                end
            end
        end

        // Sample point re-arms synchronisation after any same-cycle edge
        if (enable) begin
            lock_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= BUSY;
            cnt_q             <= '0;
            lock_q            <= 1'b0;
            bus_idle          <= 1'b0;
            hard_sync_request <= 1'b0;
            resync_valid      <= 1'b0;
            resync_lengthen   <= 1'b0;
            resync_amount     <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            lock_q            <= lock_d;
            bus_idle          <= (state_d == IDLE);
            hard_sync_request <= hs_d;
            resync_valid      <= rv_d;
            resync_lengthen   <= len_d;
            resync_amount     <= amt_d;
        end
    end

`ifdef SYNC_STATS_EN
    // Saturating event counters, updated together with their pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hard_sync_count <= '0;
            resync_count    <= '0;
        end else begin
            if (hs_d && (hard_sync_count != 16'hFFFF)) begin
                hard_sync_count <= hard_sync_count + 16'd1;
            end
            if (rv_d && (resync_count != 16'hFFFF)) begin
                resync_count <= resync_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bit_sync_ctrl.sv
// tb_bit_sync_ctrl: directed vector bench for bit_sync_ctrl
// (tseg1=7, tseg2=4, sjw=2), plus hand sequences for reset and statistics.

module tb_bit_sync_ctrl;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       signal_in;
    logic       falling_edge;
    logic [4:0] tq_pos;
    logic [4:0] tseg1;
    logic [4:0] tseg2;
    logic [1:0] sjw;
    logic       bus_idle;
    logic       hard_sync_request;
    logic       resync_valid;
    logic       resync_lengthen;
    logic [4:0] resync_amount;
`ifdef SYNC_STATS_EN
    logic [15:0] hard_sync_count;
    logic [15:0] resync_count;
`endif

    int n_checks;
    int n_fail;

    bit_sync_ctrl dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .enable            (enable),
        .signal_in         (signal_in),
        .falling_edge      (falling_edge),
        .tq_pos            (tq_pos),
        .tseg1             (tseg1),
        .tseg2             (tseg2),
        .sjw               (sjw),
        .bus_idle          (bus_idle),
        .hard_sync_request (hard_sync_request),
        .resync_valid      (resync_valid),
        .resync_lengthen   (resync_lengthen),
        .resync_amount     (resync_amount)
`ifdef SYNC_STATS_EN
        ,
        .hard_sync_count   (hard_sync_count),
        .resync_count      (resync_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic       sig;
        logic       fe;
        logic [4:0] tq;
        logic       idle;
        logic       hs;
        logic       rv;
        logic       len;
        logic [4:0] amt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic sig, input logic fe, input int tq,
                       input logic idle, input logic hs, input logic rv,
                       input logic len, input int amt);
        vec_t v;
        v.en = en; v.sig = sig; v.fe = fe; v.tq = 5'(tq);
        v.idle = idle; v.hs = hs; v.rv = rv; v.len = len; v.amt = 5'(amt);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic idle, input logic hs,
                            input logic rv, input logic len, input int amt);
        chk({tag, ".bus_idle"}, int'(bus_idle), int'(idle));
        chk({tag, ".hard_sync"}, int'(hard_sync_request), int'(hs));
        chk({tag, ".resync_valid"}, int'(resync_valid), int'(rv));
        chk({tag, ".lengthen"}, int'(resync_lengthen), int'(len));
        chk({tag, ".amount"}, int'(resync_amount), amt);
    endtask

    // One clock with the given strobes; returns #1 after the edge with strobes cleared
    task automatic step(input logic en, input logic sig, input logic fe, input logic [4:0] tq);
        enable       = en;
        signal_in    = sig;
        falling_edge = fe;
        tq_pos       = tq;
        @(posedge clock);
        #1;
        enable       = 1'b0;
        falling_edge = 1'b0;
    endtask

    // 12 recessive sample points; checks idle only after the 12th
    task automatic go_idle(input string tag);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 5'd0);
            chk($sformatf("%s.idle%0d", tag, i + 1), int'(bus_idle), (i == 11) ? 1 : 0);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        enable       = 1'b0;
        signal_in    = 1'b1;
        falling_edge = 1'b0;
        tq_pos       = 5'd0;
        tseg1        = 5'd7;
        tseg2        = 5'd4;
        sjw          = 2'd2;

        // Idle detection: 11 enables keep bus busy, 12th declares idle
        for (int i = 0; i < 11; i++) add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0,   1, 0, 0, 0, 0);
        // Hard sync from idle, then lock blocks a resync in the same bit
        add(0, 1, 1, 5,   0, 1, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 3,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0, 0);
        // Late edges
        add(0, 0, 1, 3,   0, 0, 1, 1, 2);
        add(0, 0, 0, 0,   0, 0, 0, 1, 2);
        add(0, 0, 1, 1,   0, 0, 0, 1, 2);
        add(1, 0, 0, 0,   0, 0, 0, 1, 2);
        add(0, 0, 1, 1,   0, 0, 1, 1, 1);
        add(1, 0, 0, 0,   0, 0, 0, 1, 1);
        // Early edges and segment boundaries
        add(0, 0, 1, 10,  0, 0, 1, 0, 2);
        add(1, 0, 0, 0,   0, 0, 0, 0, 2);
        add(0, 0, 1, 0,   0, 0, 0, 0, 2);
        add(0, 0, 1, 11,  0, 0, 1, 0, 1);
        add(1, 0, 0, 0,   0, 0, 0, 0, 1);
        add(0, 0, 1, 12,  0, 0, 0, 0, 1);
        add(0, 0, 1, 8,   0, 0, 1, 0, 2);
        // Enable + edge: evaluated with old lock (set), then lock cleared
        add(1, 0, 1, 3,   0, 0, 0, 0, 2);
        add(0, 0, 1, 7,   0, 0, 1, 1, 2);
        add(1, 0, 0, 0,   0, 0, 0, 1, 2);
        // Enable + edge with clear lock: resync, and the enable re-arms right away
        add(1, 0, 1, 4,   0, 0, 1, 1, 2);
        add(0, 0, 1, 9,   0, 0, 1, 0, 2);

        @(posedge clock);
        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
`ifdef SYNC_STATS_EN
        chk("reset.hs_count", int'(hard_sync_count), 0);
        chk("reset.rs_count", int'(resync_count), 0);
`endif
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].sig, vecs[i].fe, vecs[i].tq);
            chk_outs($sformatf("vec%0d", i), vecs[i].idle, vecs[i].hs, vecs[i].rv,
                     vecs[i].len, int'(vecs[i].amt));
        end

        // Reset while idle with an edge pending: everything drops immediately
        go_idle("pre_rst");
        signal_in    = 1'b1;
        falling_edge = 1'b1;
        tq_pos       = 5'd3;
        #2;
        reset_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clock);
        #1;
        falling_edge = 1'b0;
        chk_outs("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        reset_n = 1'b1;
        // Idle counter restarted from zero
        go_idle("post_rst");

        // Hard sync / resync sequence for statistics
        step(1'b0, 1'b1, 1'b1, 5'd0);
        chk_outs("hs1", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 5'd3);
        chk_outs("rs1", 1'b0, 1'b0, 1'b1, 1'b1, 2);
        step(1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 5'd10);
        chk_outs("rs2", 1'b0, 1'b0, 1'b1, 1'b0, 2);
        go_idle("hs2_idle");
        step(1'b0, 1'b1, 1'b1, 5'd2);
        chk_outs("hs2", 1'b0, 1'b1, 1'b0, 1'b0, 2);
        go_idle("hs3_idle");
        step(1'b0, 1'b1, 1'b1, 5'd6);
        chk_outs("hs3", 1'b0, 1'b1, 1'b0, 1'b0, 2);
        step(1'b0, 1'b1, 1'b0, 5'd0);
        chk("hs3_end.pulse", int'(hard_sync_request), 0);
`ifdef SYNC_STATS_EN
        chk("stats.hs_count", int'(hard_sync_count), 3);
        chk("stats.rs_count", int'(resync_count), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
